// File: rtl/seq_multiplier_if.sv
// ==== seq_multiplier_if: start/operand/result bundle for seq_multiplier ====
// ==== Rev 1.0 =============================================================
`default_nettype none

interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ==== seq_multiplier: shift-add multiplier, one result per WIDTH-cycle run; SEQ_MULT_SIGNED_EN adds two's complement ====
// ==== Rev 1.0 ===========================================================================================================
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 sign_q, sign_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      p_q      <= '0;
      done_q   <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      p_q      <= p_d;
      done_q   <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    p_d      = p_q;
    done_d   = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    sign_d   = sign_q;
`endif

    // The carry lands in sum[WIDTH]; the shifted product is {sum, mplier[W-1:1]}.
    sum  = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    prod = {sum, mplier_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          acc_d   = '0;
          count_d = '0;
`ifdef SEQ_MULT_SIGNED_EN
          // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
          mcand_d  = bus.a[WIDTH-1] ? -bus.a : bus.a;
          mplier_d = bus.b[WIDTH-1] ? -bus.b : bus.b;
          sign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
          mcand_d  = bus.a;
          mplier_d = bus.b;
`endif
        end
      end
      RUN: begin
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
          p_d     = sign_q ? -prod : prod;
`else
          p_d     = prod;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ==== tb_seq_multiplier: randomized scoreboard bench for seq_multiplier (WIDTH=8 and WIDTH=2) ====
// ==== Rev 1.0 =====================================================================================
`default_nettype none

module tb_seq_multiplier;

  localparam int W  = 8;
  localparam int W2 = 2;
  localparam int T  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(W))  bus  ();
  seq_multiplier_if #(.WIDTH(W2)) bus2 ();

  seq_multiplier #(.WIDTH(W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  seq_multiplier #(.WIDTH(W2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic [2*W-1:0] prod;
    longint         t;
  } exp8_t;

  typedef struct {
    logic [2*W2-1:0] prod;
    longint          t;
  } exp2_t;

  exp8_t q[$];
  exp2_t q2[$];
  int tests = 0;
  int fails = 0;
  longint d1, d2;

  function automatic logic [2*W-1:0] model8(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [2*W-1:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    logic [2*W-1:0] ux, uy;
    ux = x;
    uy = y;
    return ux * uy;
`endif
  endfunction

  function automatic logic [2*W2-1:0] model2(input logic [W2-1:0] x, input logic [W2-1:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [2*W2-1:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    logic [2*W2-1:0] ux, uy;
    ux = x;
    uy = y;
    return ux * uy;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitors: expected done time is accept edge + WIDTH cycles.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      d1 = $time - q[0].t;
      check("w8_busy", bus.busy, d1 < W*T);
      if (d1 == W*T + 5) begin
        check("w8_done", bus.done, 1);
        check("w8_p", bus.p, q[0].prod);
        void'(q.pop_front());
      end else begin
        check("w8_early_done", bus.done, 0);
      end
    end else if (bus.busy || bus.done) begin
      check("w8_idle_busy", bus.busy, 0);
      check("w8_spurious_done", bus.done, 0);
    end
  end

  always @(negedge clk) begin
    if (q2.size() > 0) begin
      d2 = $time - q2[0].t;
      check("w2_busy", bus2.busy, d2 < W2*T);
      if (d2 == W2*T + 5) begin
        check("w2_done", bus2.done, 1);
        check("w2_p", bus2.p, q2[0].prod);
        void'(q2.pop_front());
      end else begin
        check("w2_early_done", bus2.done, 0);
      end
    end else if (bus2.busy || bus2.done) begin
      check("w2_idle_busy", bus2.busy, 0);
      check("w2_spurious_done", bus2.done, 0);
    end
  end

  // Called just after a posedge with the model idle; accept happens at the next edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    q.push_back('{model8(x, y), $time});
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic issue2(input logic [W2-1:0] x, input logic [W2-1:0] y);
    bus2.start = 1'b1;
    bus2.a     = x;
    bus2.b     = y;
    @(posedge clk);
    q2.push_back('{model2(x, y), $time});
    #1;
    bus2.start = 1'b0;
    bus2.a     = W2'($urandom);
    bus2.b     = W2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() > 0 || q2.size() > 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 100) check("wait_idle_timeout", 64'(n), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      3:       return W'(1) << (W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bus.start  = 1'b0; bus.a  = '0; bus.b  = '0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;

    // Reset held two cycles, then three idle cycles with no change.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_p", bus.p, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_p_w2", bus2.p, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_p", bus.p, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
    end
    @(posedge clk); #1;

    // WIDTH=2 directed then random.
    issue2(2'd3, 2'd1); wait_idle();
    issue2(2'd2, 2'd3); wait_idle();
    for (int i = 0; i < 6; i++) begin
      issue2(W2'($urandom), W2'($urandom));
      wait_idle();
    end

    // WIDTH=8 directed.
    issue(8'd255, 8'd255); wait_idle();
    issue(8'd0, 8'd200);   wait_idle();

    // Start during RUN must be ignored.
    issue(8'd200, 8'd100);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // Start held high: a new accept lands one cycle after each done.
    bus.start = 1'b1;
    bus.a = 8'd13; bus.b = 8'd11;
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] nx, ny;
      @(posedge clk);
      q.push_back('{model8(bus.a, bus.b), $time});
      #1;
      nx = pick();
      ny = pick();
      bus.a = W'($urandom); bus.b = W'($urandom);
      repeat (W) @(posedge clk);
      #1;
      bus.a = nx; bus.b = ny;
      if (k == 3) bus.start = 1'b0;
    end
    wait_idle();

    // Reset in the middle of a run discards the operation.
    issue(8'd17, 8'd19);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    q.delete();
    q2.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_p", bus.p, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    repeat (10) @(posedge clk);
    #1;
    issue(8'd17, 8'd19); wait_idle();

`ifdef SEQ_MULT_SIGNED_EN
    issue(8'hFD, 8'd5);   wait_idle();
    issue(8'h80, 8'h80);  wait_idle();
    issue(8'd127, 8'hFF); wait_idle();
`endif

    // Random operations, sometimes with an ignored start mid-run.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(pick(), pick());
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, W - 3)) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule

`default_nettype wire
